tpu_mac_dot: RTL and testbench

//  Parametrised successor of the TPU functional MAC. Multiplies LANES pairs of DATA_W operands per beat,

---
 rtl/tpu_pkg.sv | 22 ++
 rtl/tpu_mac_product_tree.sv | 57 +++++
 rtl/tpu_mac_dot.sv | 143 ++++++++++++++
 tb/tb_tpu_mac_dot.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types and helpers for the TPU dot-product MAC.
package tpu_pkg;

  typedef enum logic [1:0] {StIdle, StAccum, StDrain, StHold} mac_state_e;

  // Width that holds an exact sum of `lanes` full-width products in either mode.
  function automatic int unsigned prod_sum_w(int unsigned data_w, int unsigned lanes);
    return 2 * data_w + $clog2(lanes);
  endfunction

  localparam int unsigned SatMaxW = 64;

  // Clamp bound for an acc_w-bit accumulator: all-ones for unsigned, 0x7F..F / 0x80..0 for signed.
  function automatic logic [SatMaxW-1:0] sat_bound(int unsigned acc_w, logic sgn, logic neg);
    logic [SatMaxW-1:0] ones;
    ones = {SatMaxW{1'b1}} >> (SatMaxW - acc_w);
    if (!sgn) return ones;
    if (neg) return ones & ~(ones >> 1);
    return ones >> 1;
  endfunction

endpackage

// File: rtl/tpu_mac_product_tree.sv
// Per-lane multipliers, lane adder tree and the stage-1 register of the MAC pipeline.
module tpu_mac_product_tree
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANES  = 4,
  parameter int unsigned SUM_W  = prod_sum_w(DATA_W, LANES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    valid,
  input  logic [LANES*DATA_W-1:0] a,
  input  logic [LANES*DATA_W-1:0] b,
  input  logic                    signed_mode,
  output logic                    sum_valid,
  output logic [SUM_W-1:0]        sum
);

  localparam int unsigned ProdW = 2 * DATA_W + 2;
  localparam int unsigned ExtW  = (SUM_W > ProdW) ? SUM_W : ProdW;

  logic signed [ExtW-1:0] lane_prod [LANES];
  logic signed [ExtW-1:0] tree_sum;

  // One extra operand bit lets a single signed multiplier serve both modes.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [DATA_W:0]  ax;
    logic signed [DATA_W:0]  bx;
    logic signed [ProdW-1:0] prod;
    assign ax   = {signed_mode & a[i*DATA_W+DATA_W-1], a[i*DATA_W +: DATA_W]};
    assign bx   = {signed_mode & b[i*DATA_W+DATA_W-1], b[i*DATA_W +: DATA_W]};
    assign prod = ax * bx;
    assign lane_prod[i] = ExtW'(prod);
  end

  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      tree_sum = tree_sum + lane_prod[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_valid <= 1'b0;
      sum       <= '0;
    end else if (clear) begin
      sum_valid <= 1'b0;
      sum       <= '0;
    end else begin
      sum_valid <= valid;
      if (valid) sum <= SUM_W'(tree_sum);
    end
  end

endmodule

// File: rtl/tpu_mac_dot.sv
// Multi-lane dot-product MAC with vector accumulation, valid/ready result and sticky overflow.
// Define TPU_MAC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module tpu_mac_dot
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANES  = 4,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_a,
  input  logic [LANES*DATA_W-1:0] in_b,
  input  logic                    in_signed,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_data,
  output logic [CNT_W-1:0]        out_count,
  output logic                    error
);

  localparam int unsigned PW = prod_sum_w(DATA_W, LANES);

  if (ACC_W < PW) begin : g_acc_w_check
    $error("ACC_W must be at least 2*DATA_W+$clog2(LANES)");
  end

  mac_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             mode_q, mode_d;
  logic             error_q, error_d;

  logic             fire;
  logic             tree_signed;
  logic             p_valid;
  logic [PW-1:0]    p_sum;
  logic [ACC_W:0]   acc_ext, p_ext, acc_sum;
  logic             ovf;

  assign in_ready  = reset && !clear && (state_q == StIdle || state_q == StAccum);
  assign fire      = in_valid && in_ready;
  // The first beat is multiplied before its mode is registered.
  assign tree_signed = (state_q == StIdle) ? in_signed : mode_q;

  tpu_mac_product_tree #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .SUM_W  (PW)
  ) u_tree (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .valid       (fire),
    .a           (in_a),
    .b           (in_b),
    .signed_mode (tree_signed),
    .sum_valid   (p_valid),
    .sum         (p_sum)
  );

  always_comb begin
    acc_ext = {mode_q & acc_q[ACC_W-1], acc_q};
    p_ext   = mode_q ? (ACC_W+1)'($signed(p_sum)) : (ACC_W+1)'(p_sum);
    acc_sum = acc_ext + p_ext;
    ovf     = mode_q ? (acc_sum[ACC_W] ^ acc_sum[ACC_W-1]) : acc_sum[ACC_W];
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    mode_d  = mode_q;
    error_d = error_q;

    if (p_valid) begin
`ifdef TPU_MAC_SATURATE_EN
      acc_d = ovf ? ACC_W'(sat_bound(ACC_W, mode_q, acc_sum[ACC_W])) : acc_sum[ACC_W-1:0];
`else
      acc_d = acc_sum[ACC_W-1:0];
`endif
      if (ovf) error_d = 1'b1;
    end

    if (fire) begin
      count_d = (count_q == '1) ? count_q : count_q + 1'b1;
      if (count_d == '1) error_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (fire) begin
          mode_d  = in_signed;
          state_d = in_last ? StDrain : StAccum;
        end
      end
      StAccum: if (fire && in_last) state_d = StDrain;
      StDrain: state_d = StHold;
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
          acc_d   = '0;
          count_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (clear) begin
      state_d = StIdle;
      acc_d   = '0;
      count_d = '0;
      error_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      acc_q   <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      error_q <= error_d;
    end
  end

  assign out_valid = (state_q == StHold);
  assign out_data  = acc_q;
  assign out_count = count_q;
  assign error     = error_q;

endmodule

// File: tb/tb_tpu_mac_dot.sv
// Directed self-checking bench for tpu_mac_dot with hand-computed expectations.
module tb_tpu_mac_dot;

  localparam int unsigned DataW = 8;
  localparam int unsigned Lanes = 4;
  localparam int unsigned AccW  = 24;
  localparam int unsigned CntW  = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   clear;
  logic                   in_valid;
  logic                   in_ready;
  logic [Lanes*DataW-1:0] in_a;
  logic [Lanes*DataW-1:0] in_b;
  logic                   in_signed;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [AccW-1:0]        out_data;
  logic [CntW-1:0]        out_count;
  logic                   error;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tpu_mac_dot #(
    .DATA_W (DataW),
    .LANES  (Lanes),
    .ACC_W  (AccW),
    .CNT_W  (CntW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .error     (error)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one beat at the falling edge; returns after the rising edge that takes it.
  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input logic last);
    int wait_cyc = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = sgn;
    in_last   = last;
    #1;
    while (!in_ready && wait_cyc < 20) begin
      @(negedge clk);
      #1;
      wait_cyc++;
    end
    check_eq("beat_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
  endtask

  task automatic wait_result(input string tag);
    int cyc = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      cyc++;
    end while (!out_valid && cyc < 20);
    check_eq({tag, "_latency"}, cyc, 32'd2);
  endtask

  task automatic check_result(input string tag, input logic [31:0] exp_data,
                              input logic [31:0] exp_count, input logic exp_err);
    check_eq({tag, "_data"}, {8'd0, out_data}, exp_data);
    check_eq({tag, "_count"}, {24'd0, out_count}, exp_count);
    check_eq({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
  endtask

  task automatic accept_result(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_released"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp4;
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_signed = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    #1;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_result("rst", 32'd0, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // 1: single unsigned beat
    send_beat(32'd13, 32'd15, 1'b0, 1'b1);
    wait_result("t1");
    check_result("t1", 32'd195, 32'd1, 1'b0);
    accept_result("t1");

    // 2: two beats on lane 0
    send_beat(32'd13, 32'd15, 1'b0, 1'b0);
    send_beat(32'd41, 32'd47, 1'b0, 1'b1);
    wait_result("t2");
    check_result("t2", 32'd2122, 32'd2, 1'b0);
    accept_result("t2");

    // 3: same operands, signed then unsigned
    send_beat(32'h0000_00FD, 32'h0000_0005, 1'b1, 1'b1);
    wait_result("t3s");
    check_result("t3s", 32'h00FF_FFF1, 32'd1, 1'b0);
    accept_result("t3s");
    send_beat(32'h0000_00FD, 32'h0000_0005, 1'b0, 1'b1);
    wait_result("t3u");
    check_result("t3u", 32'd1265, 32'd1, 1'b0);
    accept_result("t3u");

    // All four lanes: 1*5 + 2*6 + 3*7 + 4*8 = 70
    send_beat(32'h0403_0201, 32'h0807_0605, 1'b0, 1'b1);
    wait_result("lanes");
    check_result("lanes", 32'd70, 32'd2 - 32'd1, 1'b0);
    accept_result("lanes");

    // Mode is fixed by the first beat: (-3*1) + (-3*1) = -6
    send_beat(32'h0000_00FD, 32'h0000_0001, 1'b1, 1'b0);
    send_beat(32'h0000_00FD, 32'h0000_0001, 1'b0, 1'b1);
    wait_result("mode");
    check_result("mode", 32'h00FF_FFFA, 32'd2, 1'b0);
    accept_result("mode");

    // 4: 65 beats of 4*255*255 overflow 24 bits
    for (int i = 0; i < 65; i++) begin
      send_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, i == 64);
    end
`ifdef TPU_MAC_SATURATE_EN
    exp4 = 32'h00FF_FFFF;
`else
    exp4 = 32'd129284;
`endif
    wait_result("t4");
    check_result("t4", exp4, 32'd65, 1'b1);
    accept_result("t4");

    // 5: backpressure in HOLD; error stays sticky
    send_beat(32'd2, 32'd3, 1'b0, 1'b1);
    wait_result("t5");
    for (int i = 0; i < 3; i++) begin
      check_eq("t5_hold_data", {8'd0, out_data}, 32'd6);
      check_eq("t5_hold_ready", {31'd0, in_ready}, 32'd0);
      check_eq("t5_hold_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
    end
    check_result("t5", 32'd6, 32'd1, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("t5_in_ready_after", {31'd0, in_ready}, 32'd1);
    check_eq("t5_valid_after", {31'd0, out_valid}, 32'd0);

    // 6a: clear after three beats, with a dropped last beat in the same cycle
    for (int i = 0; i < 3; i++) send_beat(32'd9, 32'd9, 1'b0, 1'b0);
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_last  = 1'b1;
    #1;
    check_eq("t6c_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_result("t6c_flush", 32'd0, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("t6c_no_result", {31'd0, out_valid}, 32'd0);
    send_beat(32'd1, 32'd1, 1'b0, 1'b1);
    wait_result("t6c");
    check_result("t6c", 32'd1, 32'd1, 1'b0);
    accept_result("t6c");

    // 6b: reset in the middle of a vector
    for (int i = 0; i < 3; i++) send_beat(32'd7, 32'd7, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check_eq("t6r_count", {24'd0, out_count}, 32'd0);
    check_eq("t6r_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    send_beat(32'd1, 32'd1, 1'b0, 1'b1);
    wait_result("t6r");
    check_result("t6r", 32'd1, 32'd1, 1'b0);
    accept_result("t6r");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
